// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, legal prescale
// ratios and the width derivations used by the counter and sequencer.
package uart_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_MAX_PRESCALE = 32;
    localparam int unsigned DEF_PAR_MAX      = 11;

    localparam int unsigned PRESCALE_LEGAL [3] = '{8, 16, 32};

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    function automatic int unsigned calc_prsc_width(input int unsigned max_prescale);
        return $clog2(max_prescale) + 1;
    endfunction

    function automatic int unsigned calc_frame_width(input int unsigned par_max);
        return $clog2(par_max) + 1;
    endfunction

    function automatic logic is_legal_prescale(input int unsigned p);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (PRESCALE_LEGAL[i] == p) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit 3-sample majority vote: samples at h-1, h, h+1 and flags the
// vote as ready at h+2, where h = prescale/2.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRSC_WIDTH = calc_prsc_width(DEF_MAX_PRESCALE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx_in,
    input  logic [PRSC_WIDTH-2:0] edge_cnt,
    input  logic [PRSC_WIDTH-1:0] prescale,
    output logic                  majority,
    output logic                  sample_done
);

    logic [2:0]            samples_q, samples_d;
    logic [PRSC_WIDTH-1:0] half;
    logic [PRSC_WIDTH-1:0] edge_w;

    always_comb begin
        half      = prescale >> 1;
        edge_w    = {1'b0, edge_cnt};
        samples_d = samples_q;
        if (en) begin
            if (edge_w == half - 1'b1) samples_d[0] = rx_in;
            if (edge_w == half)        samples_d[1] = rx_in;
            if (edge_w == half + 1'b1) samples_d[2] = rx_in;
        end
        sample_done = en && (edge_w == half + 2'd2);
        majority    = (samples_q[0] & samples_q[1]) |
                      (samples_q[0] & samples_q[2]) |
                      (samples_q[1] & samples_q[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) samples_q <= '0;
        else     samples_q <= samples_d;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: drives the external edge/bit counter, walks
// start/data/parity/stop and reports each frame with exactly one pulse.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned MAX_PRESCALE = DEF_MAX_PRESCALE,
    parameter int unsigned PAR_MAX      = DEF_PAR_MAX,
    parameter int unsigned PRSC_WIDTH   = calc_prsc_width(MAX_PRESCALE),
    parameter int unsigned FRAME_WIDTH  = calc_frame_width(PAR_MAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic                   parity_en,
    input  logic                   parity_type,
    input  logic [PRSC_WIDTH-1:0]  prescale,
    input  logic [PRSC_WIDTH-2:0]  edge_cnt,
    input  logic [FRAME_WIDTH-2:0] bit_cnt,
    input  logic                   edge_max,
    output logic                   cnt_en,
    output logic [DATA_WIDTH-1:0]  p_data,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   busy
);

    localparam logic [FRAME_WIDTH-2:0] LAST_DATA_BIT = (FRAME_WIDTH-1)'(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic [PRSC_WIDTH-1:0] prescale_q, prescale_d;
    logic                  majority;
    logic                  sample_done;

    uart_rx_sampler #(
        .PRSC_WIDTH (PRSC_WIDTH)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .en          (cnt_en),
        .rx_in       (rx_in),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale_q),
        .majority    (majority),
        .sample_done (sample_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        prescale_d = prescale_q;
        cnt_en     = 1'b0;
        data_valid = 1'b0;
        par_err    = 1'b0;
        stp_err    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Frame configuration is frozen here so mid-frame changes are ignored.
                if (!rx_in) begin
                    state_d    = START;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                    prescale_d = prescale;
                    perr_d     = 1'b0;
                    serr_d     = 1'b0;
                end
            end
            START: begin
                cnt_en = 1'b1;
                if (sample_done && majority) state_d = IDLE;
                else if (edge_max)           state_d = DATA;
            end
            DATA: begin
                cnt_en = 1'b1;
                if (sample_done) shift_d = {majority, shift_q[DATA_WIDTH-1:1]};
                if (edge_max && bit_cnt == LAST_DATA_BIT) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                cnt_en = 1'b1;
                if (sample_done) perr_d = par_en_q & (majority ^ (^shift_q) ^ par_type_q);
                if (edge_max)    state_d = STOP;
            end
            STOP: begin
                // Leave at mid-bit so a back-to-back start bit is not missed.
                cnt_en = 1'b1;
                if (sample_done) begin
                    serr_d  = ~majority;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (perr_q)      par_err = 1'b1;
                else if (serr_q) stp_err = 1'b1;
                else begin
                    data_valid = 1'b1;
                    p_data_d   = shift_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            p_data_q   <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            prescale_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            prescale_q <= prescale_d;
        end
    end

    assign p_data = p_data_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural edge/bit counter
// alongside it; frames are scored by kind, landing cycle and payload.
module tb_uart_rx_ctrl;

    localparam int PW = 6;
    localparam int FW = 5;

    localparam int K_VALID = 1;
    localparam int K_PERR  = 2;
    localparam int K_SERR  = 3;
    localparam int K_MULTI = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          parity_en;
    logic          parity_type;
    logic [PW-1:0] prescale;
    logic [PW-2:0] edge_cnt;
    logic [FW-2:0] bit_cnt;
    logic          edge_max;
    logic          cnt_en;
    logic [7:0]    p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    int cnt_prescale = 8;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int kind;
        int cyc;
        int pd;
    } ev_t;

    typedef struct {
        int         p;
        bit         pe;
        bit         pt;
        logic [7:0] data;
        bit         pb;
        bit         sb;
        int         kind;
        int         lat;
        int         pd;
    } vec_t;

    ev_t evq[$];
    int  pdq[$];
    ev_t expq[$];
    bit  cap_pd = 1'b0;

    int last_good = 0;
    int idle_from = 0;

    uart_rx_ctrl #(
        .DATA_WIDTH   (8),
        .MAX_PRESCALE (32),
        .PAR_MAX      (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .prescale    (prescale),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .edge_max    (edge_max),
        .cnt_en      (cnt_en),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oversampling edge/bit counter that normally sits next to the sequencer.
    always @(posedge clk) begin
        if (rst || !cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (int'(edge_cnt) == cnt_prescale - 1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    assign edge_max = (int'(edge_cnt) == cnt_prescale - 1);

    always @(negedge clk) begin
        ev_t e;
        int  n;
        if (cap_pd) pdq.push_back(int'(p_data));
        cap_pd = 1'b0;
        if (!rst) begin
            n = int'(data_valid) + int'(par_err) + int'(stp_err);
            if (n != 0) begin
                e.cyc = cyc;
                e.pd  = 0;
                if (n > 1)           e.kind = K_MULTI;
                else if (data_valid) e.kind = K_VALID;
                else if (par_err)    e.kind = K_PERR;
                else                 e.kind = K_SERR;
                evq.push_back(e);
                cap_pd = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit pe,
                                               input bit pb, input bit sb);
        logic [15:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (pe) begin
            b[9]  = pb;
            b[10] = sb;
        end else begin
            b[9] = sb;
        end
        return b;
    endfunction

    // Reference outcome of a frame from the line contents alone.
    function automatic int model_kind(input logic [7:0] d, input bit pe, input bit pt,
                                      input bit pb, input bit sb);
        if (pe && (pb != ((^d) ^ pt))) return K_PERR;
        if (!sb)                       return K_SERR;
        return K_VALID;
    endfunction

    task automatic plan_frame(input int start, input int n, input int p, input int kind,
                              input logic [7:0] d);
        ev_t e;
        int  t0;
        t0 = (start > idle_from) ? start : idle_from;
        e.kind = kind;
        e.cyc  = t0 + 1 + (n - 1) * p + p / 2 + 3;
        if (kind == K_VALID) last_good = int'(d);
        e.pd = last_good;
        idle_from = e.cyc + 1;
        expq.push_back(e);
    endtask

    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit pb, input bit sb, input bit scramble,
                              output int start, output int n);
        logic [15:0] b;
        b = frame_bits(d, pe, pb, sb);
        n = pe ? 11 : 10;
        parity_en    = pe;
        parity_type  = pt;
        prescale     = PW'(p);
        cnt_prescale = p;
        start        = cyc;
        for (int i = 0; i < n; i++) begin
            rx_in = b[i];
            if (scramble && i == 2) begin
                parity_en   = ~pe;
                parity_type = ~pt;
                prescale    = PW'(8 << $urandom_range(0, 2));
            end
            tick(p);
        end
        rx_in = 1'b1;
    endtask

    task automatic verify(input string name);
        int n;
        tick(8);
        check({name, " events"}, evq.size(), expq.size());
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s ev%0d kind", name, i), evq[i].kind, expq[i].kind);
            check($sformatf("%s ev%0d cycle", name, i), evq[i].cyc, expq[i].cyc);
            if (i < pdq.size())
                check($sformatf("%s ev%0d p_data", name, i), pdq[i], expq[i].pd);
        end
        evq.delete();
        pdq.delete();
        expq.delete();
    endtask

    vec_t tbl[8];

    initial begin
        int   start;
        int   n;
        ev_t  e;
        int   c;

        tbl[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, K_VALID, 80,  'hA5};
        tbl[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, K_VALID, 172, 'h3C};
        tbl[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, K_PERR,  172, 'h3C};
        tbl[3] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, K_SERR,  80,  'h3C};
        tbl[4] = '{32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, K_VALID, 340, 'h00};
        tbl[5] = '{32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, K_VALID, 308, 'hFF};
        tbl[6] = '{8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b0, K_PERR,  88,  'hFF};
        tbl[7] = '{16, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, K_VALID, 172, 'h80};

        rst         = 1'b1;
        rx_in       = 1'b1;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        prescale    = PW'(8);
        tick(4);
        check("reset busy", int'(busy), 0);
        check("reset cnt_en", int'(cnt_en), 0);
        check("reset data_valid", int'(data_valid), 0);
        check("reset par_err", int'(par_err), 0);
        check("reset stp_err", int'(stp_err), 0);
        check("reset p_data", int'(p_data), 0);
        rst = 1'b0;
        tick(3);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].data, tbl[i].pb, tbl[i].sb,
                       1'b0, start, n);
            e.kind = tbl[i].kind;
            e.cyc  = start + tbl[i].lat;
            e.pd   = tbl[i].pd;
            expq.push_back(e);
            tick(20);
            verify($sformatf("tbl%0d", i));
        end
        last_good = 'h80;

        // Start-bit glitch: three low cycles must be rejected at sample_done.
        prescale     = PW'(8);
        cnt_prescale = 8;
        parity_en    = 1'b0;
        c = cyc;
        rx_in = 1'b0;
        tick(3);
        rx_in = 1'b1;
        check("glitch cnt_en in start", int'(cnt_en), 1);
        check("glitch busy in start", int'(busy), 1);
        tick(4);
        check("glitch busy at sample_done", int'(busy), 1);
        tick(1);
        check("glitch busy after", int'(busy), 0);
        check("glitch cnt_en after", int'(cnt_en), 0);
        check("glitch cycle", cyc, c + 8);
        tick(20);
        verify("glitch");
        idle_from = cyc;

        // Back-to-back frames with no idle gap between stop and start.
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, start, n);
        plan_frame(start, n, 8, K_VALID, 8'h12);
        send_frame(8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, start, n);
        plan_frame(start, n, 8, K_VALID, 8'h34);
        tick(10);
        verify("b2b");

        // Reset in the middle of the data bits.
        prescale     = PW'(8);
        cnt_prescale = 8;
        rx_in = 1'b0;
        tick(8);
        rx_in = 1'b1;
        tick(8);
        rx_in = 1'b0;
        tick(14);
        check("mid busy before reset", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst busy", int'(busy), 0);
        check("rst cnt_en", int'(cnt_en), 0);
        check("rst p_data", int'(p_data), 0);
        rx_in = 1'b1;
        tick(100);
        verify("rst quiet");
        last_good = 0;
        idle_from = cyc;
        send_frame(8, 1'b0, 1'b0, 8'h6B, 1'b0, 1'b1, 1'b0, start, n);
        plan_frame(start, n, 8, K_VALID, 8'h6B);
        tick(10);
        verify("rst fresh");

        // Randomised frames with mid-frame configuration changes.
        idle_from = cyc;
        for (int i = 0; i < 40; i++) begin
            int         p;
            bit         pe;
            bit         pt;
            bit         pb;
            logic [7:0] d;
            p  = 8 << $urandom_range(0, 2);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            pb = (^d) ^ pt;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            send_frame(p, pe, pt, d, pb, 1'b1, 1'b1, start, n);
            plan_frame(start, n, p, model_kind(d, pe, pt, pb, 1'b1), d);
            tick($urandom_range(1, 10));
        end
        tick(10);
        verify("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
